// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch-offset widening behind a
// valid/ready handshake with a two-entry (main + skid) output buffer and a transfer counter.
module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_ovf_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  localparam int E = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BR    = 2'b11;

  // ---------------------------------------------------------------------------
  // Extension datapath (combinational, feeds whichever register is loading)
  // ---------------------------------------------------------------------------
  logic signed [IN_W-1:0]  d_signed;
  logic signed [OUT_W-1:0] sext;
  logic        [OUT_W-1:0] zext;
  logic        [OUT_W-1:0] ext_data;
  logic                    ext_ovf;
  logic                    br_ovf;

  assign d_signed = in_data_i;
  // Size casts keep this legal when E == 0, where a zero-count replication would not be.
  assign sext     = OUT_W'(d_signed);
  assign zext     = OUT_W'(in_data_i);

  // Significant bits are lost when the bits shifted out differ from the new sign bit.
  always_comb begin
    br_ovf = 1'b0;
    for (int i = OUT_W - BR_SHIFT; i < OUT_W; i++) begin
      if (sext[i] != sext[OUT_W-1-BR_SHIFT]) br_ovf = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    ext_data = '0;
    ext_ovf  = 1'b0;
    case (in_mode_i)
      MODE_SIGN:  ext_data = sext;
      MODE_ZERO:  ext_data = zext;
      MODE_UPPER: ext_data = zext << E;
      MODE_BR: begin
        ext_data = sext << BR_SHIFT;
        ext_ovf  = br_ovf;
      end
      default: ext_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main/skid buffer control
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             main_ovf_q,   main_ovf_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_ovf_q,   skid_ovf_d;
  logic             in_ready_q,   in_ready_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic in_acc;
  logic out_xfer;
  logic main_free;

  assign in_acc    = in_valid_i & in_ready_q;
  assign out_xfer  = main_valid_q & out_ready_i;
  assign main_free = ~main_valid_q | out_xfer;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ovf_d   = main_ovf_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ovf_d   = skid_ovf_q;

    if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; a same-cycle input takes its place in skid.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ovf_d   = skid_ovf_q;
        skid_valid_d = in_acc;
        if (in_acc) begin
          skid_data_d = ext_data;
          skid_ovf_d  = ext_ovf;
        end
      end else begin
        main_valid_d = in_acc;
        if (in_acc) begin
          main_data_d = ext_data;
          main_ovf_d  = ext_ovf;
        end
      end
    end else if (in_acc) begin
      // in_ready_q guarantees the skid is empty whenever an input is accepted.
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_ovf_d   = ext_ovf;
    end

    in_ready_d = ~skid_valid_d;
    cnt_d      = cnt_q + CNT_W'(out_xfer);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: data registers are reset too, since out_data_o must read zero
      // out of reset and these are only a handful of flops, not a memory.
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ovf_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ovf_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ovf_q   <= main_ovf_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ovf_q   <= skid_ovf_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_ovf_o   = main_ovf_q;
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a default-parameter instance and a
// narrow instance (OUT_W=17, CNT_W=4) for overflow and counter-wrap cases.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters
  logic        rst_m, in_valid_m, in_ready_m, out_valid_m, out_ready_m, out_ovf_m;
  logic [15:0] in_data_m;
  logic [1:0]  in_mode_m;
  logic [31:0] out_data_m;
  logic [15:0] cnt_m;

  // Narrow instance
  logic        rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [15:0] in_data_a;
  logic [1:0]  in_mode_a;
  logic [16:0] out_data_a;
  logic [3:0]  cnt_a;

  imm_extend_pipe dut_m (
    .clk_i(clk), .rst_i(rst_m),
    .in_valid_i(in_valid_m), .in_ready_o(in_ready_m),
    .in_data_i(in_data_m), .in_mode_i(in_mode_m),
    .out_valid_o(out_valid_m), .out_ready_i(out_ready_m),
    .out_data_o(out_data_m), .out_ovf_o(out_ovf_m),
    .xfer_cnt_o(cnt_m)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(17), .BR_SHIFT(2), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
    .in_data_i(in_data_a), .in_mode_i(in_mode_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
    .out_data_o(out_data_a), .out_ovf_o(out_ovf_a),
    .xfer_cnt_o(cnt_a)
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vec_m [8];
  vec_t vec_a [6];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_main();
    rst_m = 1'b0;
    step();
    rst_m = 1'b1;
  endtask

  int outs;
  logic [31:0] exp_next;

  initial begin
    vec_m[0] = '{16'h8001, 2'b00, 32'hFFFF8001, 1'b0};
    vec_m[1] = '{16'h8001, 2'b01, 32'h00008001, 1'b0};
    vec_m[2] = '{16'h8001, 2'b10, 32'h80010000, 1'b0};
    vec_m[3] = '{16'h8001, 2'b11, 32'hFFFE0004, 1'b0};
    vec_m[4] = '{16'h7FFF, 2'b00, 32'h00007FFF, 1'b0};
    vec_m[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC, 1'b0};
    vec_m[6] = '{16'hFFFF, 2'b10, 32'hFFFF0000, 1'b0};
    vec_m[7] = '{16'h0000, 2'b11, 32'h00000000, 1'b0};

    // 17-bit results: S is the 17-bit sign extension, ovf looks at S[16:14]
    vec_a[0] = '{16'h4000, 2'b11, 32'h10000, 1'b1};
    vec_a[1] = '{16'h0FFF, 2'b11, 32'h03FFC, 1'b0};
    vec_a[2] = '{16'hC000, 2'b11, 32'h10000, 1'b0};
    vec_a[3] = '{16'h8000, 2'b11, 32'h00000, 1'b1};
    vec_a[4] = '{16'h8001, 2'b00, 32'h18001, 1'b0};
    vec_a[5] = '{16'h8001, 2'b10, 32'h10002, 1'b0};

    rst_m = 1'b1; rst_a = 1'b1;
    in_valid_m = 1'b0; in_data_m = '0; in_mode_m = '0; out_ready_m = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; in_mode_a = '0; out_ready_a = 1'b1;
    #2;
    rst_m = 1'b0; rst_a = 1'b0;
    in_valid_m = 1'b1;  // must be ignored while in reset
    #1;
    check("rst_out_valid", 64'(out_valid_m), 64'd0);
    check("rst_out_data",  64'(out_data_m),  64'd0);
    check("rst_out_ovf",   64'(out_ovf_m),   64'd0);
    check("rst_cnt",       64'(cnt_m),       64'd0);
    check("rst_in_ready",  64'(in_ready_m),  64'd1);
    step();
    step();
    check("rst_ignore_valid", 64'(out_valid_m), 64'd0);
    in_valid_m = 1'b0;
    rst_m = 1'b1; rst_a = 1'b1;
    step();

    // Modes, one input per cycle, each result one cycle after accept
    for (int i = 0; i < 8; i++) begin
      in_valid_m = 1'b1;
      in_data_m  = vec_m[i].d;
      in_mode_m  = vec_m[i].m;
      step();
      check($sformatf("mode_valid[%0d]", i), 64'(out_valid_m), 64'd1);
      check($sformatf("mode_data[%0d]", i),  64'(out_data_m),  64'(vec_m[i].exp_data));
      check($sformatf("mode_ovf[%0d]", i),   64'(out_ovf_m),   64'(vec_m[i].exp_ovf));
    end
    in_valid_m = 1'b0;
    step();
    check("mode_drained", 64'(out_valid_m), 64'd0);
    check("mode_cnt",     64'(cnt_m),       64'd8);

    // Overflow on the narrow instance
    for (int i = 0; i < 6; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = vec_a[i].d;
      in_mode_a  = vec_a[i].m;
      step();
      check($sformatf("ovf_data[%0d]", i), 64'(out_data_a), 64'(vec_a[i].exp_data));
      check($sformatf("ovf_flag[%0d]", i), 64'(out_ovf_a),  64'(vec_a[i].exp_ovf));
    end
    in_valid_a = 1'b0;
    step();

    // Backpressure: 1 in main, 2 in skid, 3 and 4 wait for in_ready
    reset_main();
    out_ready_m = 1'b0;
    in_mode_m   = 2'b01;
    in_valid_m  = 1'b1; in_data_m = 16'd1;
    step();
    check("bp_main1",      64'(out_data_m), 64'd1);
    check("bp_ready_one",  64'(in_ready_m), 64'd1);
    in_data_m = 16'd2;
    step();
    check("bp_ready_drop", 64'(in_ready_m), 64'd0);
    check("bp_hold1",      64'(out_data_m), 64'd1);
    in_data_m = 16'd3;
    step();
    check("bp_stable_data",  64'(out_data_m),  64'd1);
    check("bp_stable_valid", 64'(out_valid_m), 64'd1);
    check("bp_still_full",   64'(in_ready_m),  64'd0);
    out_ready_m = 1'b1;
    step();
    check("bp_out2",       64'(out_data_m), 64'd2);
    check("bp_ready_rise", 64'(in_ready_m), 64'd1);
    step();
    check("bp_out3", 64'(out_data_m), 64'd3);
    in_data_m = 16'd4;
    step();
    check("bp_out4", 64'(out_data_m), 64'd4);
    in_valid_m = 1'b0;
    step();
    check("bp_empty", 64'(out_valid_m), 64'd0);
    check("bp_cnt",   64'(cnt_m),       64'd4);

    // Throughput: 100 back-to-back inputs
    reset_main();
    outs = 0;
    exp_next = 32'd0;
    for (int i = 0; i < 100; i++) begin
      in_valid_m = 1'b1;
      in_data_m  = 16'(i);
      step();
      if (out_valid_m && out_data_m == exp_next) begin
        outs++;
        exp_next++;
      end
    end
    in_valid_m = 1'b0;
    step();
    check("tp_outputs", 64'(outs),        64'd100);
    check("tp_cnt",     64'(cnt_m),       64'd100);
    check("tp_idle",    64'(out_valid_m), 64'd0);

    // Counter wrap on the 4-bit instance: 17 transfers
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 16'(i);
      in_mode_a  = 2'b01;
      step();
    end
    in_valid_a = 1'b0;
    step();
    check("wrap_cnt", 64'(cnt_a), 64'd1);

    // Reset mid-stream with main and skid full
    out_ready_m = 1'b1;
    in_valid_m  = 1'b1; in_mode_m = 2'b01; in_data_m = 16'h0011;
    step();
    out_ready_m = 1'b0;
    in_data_m = 16'h0022;
    step();
    in_data_m = 16'h0033;
    step();
    check("mid_full", 64'(in_ready_m), 64'd0);
    rst_m = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid_m), 64'd0);
    check("mid_rst_ready", 64'(in_ready_m),  64'd1);
    check("mid_rst_cnt",   64'(cnt_m),       64'd0);
    step();
    rst_m = 1'b1;
    in_valid_m  = 1'b0;
    out_ready_m = 1'b1;
    step();
    check("mid_no_stale", 64'(out_valid_m), 64'd0);
    in_valid_m = 1'b1; in_data_m = 16'h0044;
    step();
    check("mid_new_data", 64'(out_data_m), 64'h44);
    in_valid_m = 1'b0;
    step();
    check("mid_new_only", 64'(out_valid_m), 64'd0);
    check("mid_cnt",      64'(cnt_m),       64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
